// File: rtl/demux_pkg.sv
// Shared helpers for the stream demultiplexer: select width and lane slicing.
package demux_pkg;
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int lane_off(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/stream_demux_if.sv
// Producer-side and consumer-side handshake bundle of the stream demultiplexer.
interface stream_demux_if
  import demux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = sel_w(NUM_CH);

  logic [WIDTH-1:0]        in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_bcast;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic                    drop_err;

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid, drop_err
  );

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid, drop_err
  );
endinterface

// File: rtl/demux_slot.sv
// One-entry output holding slot: load wins over drain, optional zero mask when idle.
module demux_slot #(
  parameter int WIDTH     = 8,
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  logic [WIDTH-1:0] lane;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      lane  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      lane  <= wdata;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  generate
    if (ZERO_IDLE) begin : g_mask
      assign data = valid ? lane : '0;
    end else begin : g_raw
      assign data = lane;
    end
  endgenerate
endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH demux: select decode, in_ready and drop reporting around per-lane slots.
module stream_demux
  import demux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_CH    = 4,
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  stream_demux_if.slave bus
);
  localparam int SEL_W = sel_w(NUM_CH);

  logic [NUM_CH-1:0] free, hit, load;
  logic              oor, acc, in_ready;

  generate
    // A full power-of-two select range can never point past the last lane.
    if (NUM_CH == (2 ** SEL_W)) begin : g_full
      assign oor = 1'b0;
    end else begin : g_part
      assign oor = (bus.in_sel >= SEL_W'(NUM_CH));
    end
  endgenerate

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign free[i] = !bus.out_valid[i] || bus.out_ready[i];
    assign hit[i]  = (bus.in_sel == SEL_W'(i));
    assign load[i] = acc && (bus.in_bcast || hit[i]);

    demux_slot #(.WIDTH(WIDTH), .ZERO_IDLE(ZERO_IDLE)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .wdata (bus.in_data),
      .ready (bus.out_ready[i]),
      .valid (bus.out_valid[i]),
      .data  (bus.out_data[lane_off(i, WIDTH) +: WIDTH])
    );
  end

  // Broadcast waits for every slot so it never lands on a partial set of lanes.
  always_comb begin
    in_ready = 1'b0;
    if (bus.in_bcast)  in_ready = &free;
    else if (oor)      in_ready = 1'b1;
    else               in_ready = |(hit & free);
  end

  assign bus.in_ready = in_ready;
  assign acc          = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) bus.drop_err <= 1'b0;
    else     bus.drop_err <= acc && !bus.in_bcast && oor;
  end
endmodule

// File: tb/tb_stream_demux.sv
// Directed bench: scoreboard on the 4-lane instance, inline checks on 3-lane and unmasked instances.
module tb_stream_demux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(8), .NUM_CH(4)) ia ();
  stream_demux_if #(.WIDTH(8), .NUM_CH(3)) ib ();
  stream_demux_if #(.WIDTH(8), .NUM_CH(4)) ic ();

  stream_demux #(.WIDTH(8), .NUM_CH(4), .ZERO_IDLE(1'b1)) u_a (.clk(clk), .rst(rst), .bus(ia));
  stream_demux #(.WIDTH(8), .NUM_CH(3), .ZERO_IDLE(1'b1)) u_b (.clk(clk), .rst(rst), .bus(ib));
  stream_demux #(.WIDTH(8), .NUM_CH(4), .ZERO_IDLE(1'b0)) u_c (.clk(clk), .rst(rst), .bus(ic));

  int errors = 0;
  int checks = 0;
  logic [7:0] q[4][$];
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake completing on the 4-lane instance must match the oldest expected word.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        if (ia.out_valid[i] && ia.out_ready[i]) begin
          if (q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected lane=%0d actual=%0h required=none", i, ia.out_data[i*8 +: 8]);
          end else begin
            chk($sformatf("sb_lane%0d", i), 64'(ia.out_data[i*8 +: 8]), 64'(q[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    ia.in_valid = 1'b1; ia.in_data = 8'h77; ia.in_sel = 2'd0; ia.in_bcast = 1'b0; ia.out_ready = 4'h0;
    ib.in_valid = 1'b1; ib.in_data = 8'h77; ib.in_sel = 2'd3; ib.in_bcast = 1'b0; ib.out_ready = 3'h0;
    ic.in_valid = 1'b1; ic.in_data = 8'h77; ic.in_sel = 2'd1; ic.in_bcast = 1'b0; ic.out_ready = 4'h0;

    // Reset with in_valid held high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_a", 64'(ia.out_valid), 64'h0);
    chk("rst_data_a",  64'(ia.out_data),  64'h0);
    chk("rst_drop_b",  64'(ib.drop_err),  64'h0);
    chk("rst_data_c",  64'(ic.out_data),  64'h0);
    @(posedge clk); #1;
    ia.in_valid = 1'b0; ib.in_valid = 1'b0; ic.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_noload_a", 64'(ia.out_valid), 64'h0);
    chk("rst_noload_c", 64'(ic.out_valid), 64'h0);
    @(posedge clk); #1;

    // Routing: one word per lane on consecutive cycles
    ia.out_ready = 4'hF;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ia.in_valid = 1'b1;
      ia.in_data  = 8'(8'hA1 + i);
      ia.in_sel   = 2'(i);
      @(negedge clk);
      chk("route_ready", 64'(ia.in_ready), 64'h1);
      if (i > 0) begin
        chk("route_valid", 64'(ia.out_valid), 64'(1) << (i - 1));
        chk("route_data",  64'(ia.out_data),  64'(8'hA0 + i) << ((i - 1) * 8));
      end
      @(posedge clk);
      q[i].push_back(8'(8'hA1 + i));
      #1;
    end
    ia.in_valid = 1'b0;
    @(negedge clk);
    chk("route_valid_last", 64'(ia.out_valid), 64'h8);
    chk("route_data_last",  64'(ia.out_data),  64'hA400_0000);
    tick();

    // Back-pressure on lane 2
    ia.out_ready = 4'b1011;
    ia.in_valid = 1'b1; ia.in_data = 8'h11; ia.in_sel = 2'd2;
    @(negedge clk);
    chk("bp_ready_first", 64'(ia.in_ready), 64'h1);
    @(posedge clk); q[2].push_back(8'h11); #1;
    ia.in_data = 8'h22;
    @(negedge clk);
    chk("bp_ready_blocked", 64'(ia.in_ready),  64'h0);
    chk("bp_valid_hold",    64'(ia.out_valid), 64'h4);
    chk("bp_data_hold",     64'(ia.out_data),  64'h0011_0000);
    tick();
    @(negedge clk);
    chk("bp_ready_blocked2", 64'(ia.in_ready), 64'h0);
    @(posedge clk); #1;
    ia.out_ready = 4'hF;
    @(negedge clk);
    chk("bp_ready_release", 64'(ia.in_ready), 64'h1);
    @(posedge clk); q[2].push_back(8'h22); #1;
    ia.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_nobubble_valid", 64'(ia.out_valid), 64'h4);
    chk("bp_nobubble_data",  64'(ia.out_data),  64'h0022_0000);
    tick();

    // Broadcast stalls behind a full lane 1
    ia.out_ready = 4'b1101;
    ia.in_valid = 1'b1; ia.in_data = 8'h33; ia.in_sel = 2'd1; ia.in_bcast = 1'b0;
    @(negedge clk);
    chk("bc_fill_ready", 64'(ia.in_ready), 64'h1);
    @(posedge clk); q[1].push_back(8'h33); #1;
    ia.in_data = 8'h5A; ia.in_bcast = 1'b1; ia.in_sel = 2'd3;
    @(negedge clk);
    chk("bc_ready_stall", 64'(ia.in_ready),  64'h0);
    chk("bc_valid_stall", 64'(ia.out_valid), 64'h2);
    tick();
    @(negedge clk);
    chk("bc_ready_stall2", 64'(ia.in_ready),  64'h0);
    chk("bc_partial",      64'(ia.out_valid), 64'h2);
    @(posedge clk); #1;
    ia.out_ready = 4'hF;
    @(negedge clk);
    chk("bc_ready_release", 64'(ia.in_ready), 64'h1);
    @(posedge clk);
    for (int i = 0; i < 4; i++) q[i].push_back(8'h5A);
    #1;
    ia.in_valid = 1'b0; ia.in_bcast = 1'b0;
    @(negedge clk);
    chk("bc_valid_all", 64'(ia.out_valid), 64'hF);
    chk("bc_data_all",  64'(ia.out_data),  64'h5A5A_5A5A);
    tick();
    @(negedge clk);
    chk("bc_drained", 64'(ia.out_valid), 64'h0);
    mon_en = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("sb_empty%0d", i), 64'(q[i].size()), 64'h0);
    @(posedge clk); #1;

    // Out-of-range select on 3 lanes, back-to-back drops
    ib.in_valid = 1'b1; ib.in_data = 8'h10; ib.in_sel = 2'd0;
    @(negedge clk);
    chk("oor_fill_ready", 64'(ib.in_ready), 64'h1);
    @(posedge clk); #1;
    ib.in_sel = 2'd3; ib.in_data = 8'hFF;
    @(negedge clk);
    chk("oor_ready",     64'(ib.in_ready),  64'h1);
    chk("oor_drop_pre",  64'(ib.drop_err),  64'h0);
    chk("oor_valid_pre", 64'(ib.out_valid), 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("oor_drop1", 64'(ib.drop_err), 64'h1);
    @(posedge clk); #1;
    ib.in_valid = 1'b0; ib.in_sel = 2'd0;
    @(negedge clk);
    chk("oor_drop2",      64'(ib.drop_err),  64'h1);
    chk("oor_valid_keep", 64'(ib.out_valid), 64'h1);
    chk("oor_full_ready", 64'(ib.in_ready),  64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("oor_drop_end", 64'(ib.drop_err),  64'h0);
    chk("oor_data",     64'(ib.out_data),  64'h00_0010);
    @(posedge clk); #1;

    // Unmasked lanes keep their last word after draining
    ic.out_ready = 4'hF;
    ic.in_valid = 1'b1; ic.in_data = 8'h3C; ic.in_sel = 2'd0;
    @(posedge clk); #1;
    ic.in_valid = 1'b0;
    @(negedge clk);
    chk("zi0_valid",  64'(ic.out_valid),     64'h1);
    chk("zi0_data",   64'(ic.out_data[7:0]), 64'h3C);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zi0_idle_valid", 64'(ic.out_valid), 64'h0);
    chk("zi0_idle_data",  64'(ic.out_data),  64'h0000_003C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
